interval_timer_ctrl: RTL and testbench
======================================

// Module: interval_timer_ctrl
// PURPOSE
//  Controller that sequences a WIDTH-bit up-counter as a programmable interval timer.
//  - Adds a prescaler, period compare, one-shot/periodic modes, start/stop control and a latched interrupt.
//  - Sits between a register/control interface and the counter datapath.
//  - Expiry interval in clocks = period * (prescale + 1).
// PARAMETERS
//  WIDTH       16  width of counter and period
//  PRESCALE_W   8  width of prescale divider
// PORTS
//  clk        in   1           clock; all logic on posedge
//  n_reset    in   1           reset, synchronous, active-low
//  start      in   1           pulse: latch period/prescale/mode, (re)start timer
//  stop       in   1           pulse: halt timer, hold count
//  periodic   in   1           sampled on start: 1=auto-reload, 0=one-shot
//  period     in   WIDTH       sampled on start: counts per expiry; 0 = illegal
//  prescale   in   PRESCALE_W  sampled on start: count step every prescale+1 clocks
//  irq_ack    in   1           clears irq and overrun
//  count      out  WIDTH       current count value
//  busy       out  1           1 while in RUN
//  tick       out  1           registered one-cycle expiry pulse
//  irq        out  1           sticky expiry flag
//  overrun    out  1           sticky: expiry occurred while irq already set
//  cfg_err    out  1           one-cycle pulse: start with period==0 rejected
// BEHAVIOUR
//  Reset (n_reset=0 at posedge): state=IDLE.
//   - count, prescaler count, latched config and all outputs are 0.
//   - Reset overrides every other input, including mid-RUN.
//  States: IDLE, RUN. busy = (state==RUN).
//  Start handling (any state):
//   - start=1 and stop=0 and period!=0: latch period/prescale/periodic; count<=0, pre_cnt<=0; state<=RUN.
//   - start while RUN is a restart; the pending step is discarded and no tick is generated.
//   - start with period==0: cfg_err=1 for one cycle; state and count unchanged.
//  Stop handling:
//   - stop=1: state<=IDLE; count and pre_cnt hold; no tick that cycle.
//   - stop has priority over start and over a coincident expiry.
//  RUN, each clock:
//   - If pre_cnt==prescale_q: pre_cnt<=0 and a count step occurs; otherwise pre_cnt<=pre_cnt+1.
//   - Step with count!=period_q-1: count<=count+1.
//   - Step with count==period_q-1 (expiry): count<=0, tick<=1.
//       periodic_q=1: stay in RUN.
//       periodic_q=0: state<=IDLE.
//  Latency: start sampled at edge N, prescale 0 → first step at edge N+1; first tick high after edge N+period.
//  Interrupt flags:
//   - tick sets irq; irq_ack clears irq and overrun.
//   - Tick and irq_ack in the same cycle: irq=1, overrun unchanged (set wins).
//   - Tick while irq=1 and irq_ack=0: overrun<=1.
//  Arithmetic: count never exceeds period_q-1; no wrap past period_q.
//   - period=1: expiry on every step.
//   - prescale=0: step every clock.
//  In IDLE: count holds its last value (0 after expiry or reset); tick=0.
// TESTING
//  1. Reset, start period=3 prescale=0 periodic=1 → count 1,2,0; tick every 3 clks; irq=1 after first tick.
//  2. period=2 prescale=3 periodic=0 → tick once 8 clks after start; then busy=0, count=0.
//  3. Tick again without irq_ack → overrun=1; irq_ack → irq=0, overrun=0 next cycle.
//  4. Stop at count=5 (period=10) → busy=0, count stays 5; stop+start same cycle → stays IDLE.
//  5. Start with period=0 → cfg_err pulse, busy stays 0; restart mid-RUN → count back to 0, no tick.
//  6. n_reset low mid-RUN with irq=1 → all outputs 0 next cycle; irq_ack coincident with tick → irq stays 1.

Source files
------------

// File: rtl/interval_timer_ctrl.sv
// Programmable interval timer controller: prescaler, period compare, one-shot or
// periodic reload, start/stop control and sticky interrupt/overrun flags.
module interval_timer_ctrl #(
  parameter int WIDTH      = 16,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  periodic,
  input  logic [WIDTH-1:0]      period,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  irq_ack,
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  tick,
  output logic                  irq,
  output logic                  overrun,
  output logic                  cfg_err
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [WIDTH-1:0]      count_q, count_d;
  logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [WIDTH-1:0]      period_q, period_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic                  periodic_q, periodic_d;
  logic                  tick_q, tick_d;
  logic                  irq_q, irq_d;
  logic                  overrun_q, overrun_d;
  logic                  cfg_err_q, cfg_err_d;

  logic step;
  logic expire;

  assign step   = (state_q == RUN) && (pre_cnt_q == prescale_q);
  assign expire = step && (count_q == (period_q - WIDTH'(1)));

  // Priority: stop > start > normal RUN stepping. A restart discards the pending step.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    pre_cnt_d  = pre_cnt_q;
    period_d   = period_q;
    prescale_d = prescale_q;
    periodic_d = periodic_q;
    tick_d     = 1'b0;
    cfg_err_d  = 1'b0;

    if (stop) begin
      state_d = IDLE;
    end else if (start) begin
      if (period != '0) begin
        period_d   = period;
        prescale_d = prescale;
        periodic_d = periodic;
        count_d    = '0;
        pre_cnt_d  = '0;
        state_d    = RUN;
      end else begin
        cfg_err_d = 1'b1;
      end
    end else if (state_q == RUN) begin
      if (step) begin
        pre_cnt_d = '0;
        if (expire) begin
          count_d = '0;
          tick_d  = 1'b1;
          if (!periodic_q) state_d = IDLE;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);
      end
    end
  end

  // The flags react to the expiry on the same edge that raises tick; setting wins over ack.
  always_comb begin
    irq_d     = irq_q;
    overrun_d = overrun_q;
    if (tick_d) begin
      irq_d = 1'b1;
      if (irq_q && !irq_ack) overrun_d = 1'b1;
    end else if (irq_ack) begin
      irq_d     = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      pre_cnt_q  <= '0;
      period_q   <= '0;
      prescale_q <= '0;
      periodic_q <= 1'b0;
      tick_q     <= 1'b0;
      irq_q      <= 1'b0;
      overrun_q  <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      pre_cnt_q  <= pre_cnt_d;
      period_q   <= period_d;
      prescale_q <= prescale_d;
      periodic_q <= periodic_d;
      tick_q     <= tick_d;
      irq_q      <= irq_d;
      overrun_q  <= overrun_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  // busy is the FSM state itself (two states).
  assign busy    = (state_q == RUN);
  assign count   = count_q;
  assign tick    = tick_q;
  assign irq     = irq_q;
  assign overrun = overrun_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Directed bench for interval_timer_ctrl: a vector table stepped one clock per row,
// followed by hand-written long-prescale and periodic-spacing sequences.
module tb_interval_timer_ctrl;

  logic        clk;
  logic        n_reset;
  logic        start;
  logic        stop;
  logic        periodic;
  logic [15:0] period;
  logic [7:0]  prescale;
  logic        irq_ack;
  logic [15:0] count;
  logic        busy;
  logic        tick;
  logic        irq;
  logic        overrun;
  logic        cfg_err;

  int tests;
  int fails;

  interval_timer_ctrl #(.WIDTH(16), .PRESCALE_W(8)) dut (
    .clk      (clk),
    .n_reset  (n_reset),
    .start    (start),
    .stop     (stop),
    .periodic (periodic),
    .period   (period),
    .prescale (prescale),
    .irq_ack  (irq_ack),
    .count    (count),
    .busy     (busy),
    .tick     (tick),
    .irq      (irq),
    .overrun  (overrun),
    .cfg_err  (cfg_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rn, st, sp, pe;
    logic [15:0] per;
    logic [7:0]  pre;
    logic        ack;
    logic [15:0] e_cnt;
    logic        e_busy, e_tick, e_irq, e_ovr, e_cfg;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rn, st, sp, pe, input logic [15:0] per,
                     input logic [7:0] pre, input logic ack, input logic [15:0] ec,
                     input logic eb, et, ei, eo, ecf);
    vec_t v;
    v.rn = rn; v.st = st; v.sp = sp; v.pe = pe; v.per = per; v.pre = pre; v.ack = ack;
    v.e_cnt = ec; v.e_busy = eb; v.e_tick = et; v.e_irq = ei; v.e_ovr = eo; v.e_cfg = ecf;
    vecs.push_back(v);
  endtask

  // quiet row: no control inputs, only expected outputs
  task automatic idle(input logic ack, input logic [15:0] ec,
                      input logic eb, et, ei, eo, ecf);
    add(1, 0, 0, 0, 16'd0, 8'd0, ack, ec, eb, et, ei, eo, ecf);
  endtask

  // driver tasks
  task automatic drive_idle();
    n_reset = 1'b1; start = 1'b0; stop = 1'b0; periodic = 1'b0;
    period = 16'd0; prescale = 8'd0; irq_ack = 1'b0;
  endtask

  task automatic apply(input vec_t v, input int idx);
    n_reset = v.rn; start = v.st; stop = v.sp; periodic = v.pe;
    period = v.per; prescale = v.pre; irq_ack = v.ack;
    @(posedge clk);
    #1;
    tests++;
    if (count !== v.e_cnt || busy !== v.e_busy || tick !== v.e_tick ||
        irq !== v.e_irq || overrun !== v.e_ovr || cfg_err !== v.e_cfg) begin
      fails++;
      $display("FAIL vec%0d: got cnt=%0d busy=%b tick=%b irq=%b ovr=%b cfg=%b, want cnt=%0d busy=%b tick=%b irq=%b ovr=%b cfg=%b",
               idx, count, busy, tick, irq, overrun, cfg_err,
               v.e_cnt, v.e_busy, v.e_tick, v.e_irq, v.e_ovr, v.e_cfg);
    end
  endtask

  task automatic check(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, actual, expected);
    end
  endtask

  task automatic pulse_start(input logic pe, input logic [15:0] per, input logic [7:0] pre);
    start = 1'b1; periodic = pe; period = per; prescale = pre;
    @(posedge clk);
    #1;
    drive_idle();
  endtask

  initial begin
    int n;
    int last;
    int gap;
    int ticks;
    tests = 0;
    fails = 0;
    drive_idle();
    n_reset = 1'b0;

    // reset
    add(0, 0, 0, 0, 16'd0, 8'd0, 0, 16'd0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 16'd0, 8'd0, 0, 16'd0, 0, 0, 0, 0, 0);
    // period 3, prescale 0, periodic: 1,2,0 with tick every third clock
    add(1, 1, 0, 1, 16'd3, 8'd0, 0, 16'd0, 1, 0, 0, 0, 0);
    idle(0, 16'd1, 1, 0, 0, 0, 0);
    idle(0, 16'd2, 1, 0, 0, 0, 0);
    idle(0, 16'd0, 1, 1, 1, 0, 0);
    idle(0, 16'd1, 1, 0, 1, 0, 0);
    idle(1, 16'd2, 1, 0, 0, 0, 0);
    idle(0, 16'd0, 1, 1, 1, 0, 0);
    idle(0, 16'd1, 1, 0, 1, 0, 0);
    idle(0, 16'd2, 1, 0, 1, 0, 0);
    idle(0, 16'd0, 1, 1, 1, 1, 0);   // second tick unacked: overrun
    idle(1, 16'd1, 1, 0, 0, 0, 0);   // ack clears both
    idle(0, 16'd2, 1, 0, 0, 0, 0);
    idle(1, 16'd0, 1, 1, 1, 0, 0);   // ack coincident with tick: irq stays set
    idle(0, 16'd1, 1, 0, 1, 0, 0);
    idle(0, 16'd2, 1, 0, 1, 0, 0);
    idle(0, 16'd0, 1, 1, 1, 1, 0);
    idle(0, 16'd1, 1, 0, 1, 1, 0);
    idle(0, 16'd2, 1, 0, 1, 1, 0);
    idle(1, 16'd0, 1, 1, 1, 1, 0);   // tick+ack with overrun set: overrun unchanged
    add(1, 0, 1, 0, 16'd0, 8'd0, 0, 16'd0, 0, 0, 1, 1, 0);  // stop beats coincident expiry? no: count 0 hold
    idle(1, 16'd0, 0, 0, 0, 0, 0);
    // period 2, prescale 3, one-shot: tick 8 clocks after start
    add(1, 1, 0, 0, 16'd2, 8'd3, 0, 16'd0, 1, 0, 0, 0, 0);
    idle(0, 16'd0, 1, 0, 0, 0, 0);
    idle(0, 16'd0, 1, 0, 0, 0, 0);
    idle(0, 16'd0, 1, 0, 0, 0, 0);
    idle(0, 16'd1, 1, 0, 0, 0, 0);
    idle(0, 16'd1, 1, 0, 0, 0, 0);
    idle(0, 16'd1, 1, 0, 0, 0, 0);
    idle(0, 16'd1, 1, 0, 0, 0, 0);
    idle(0, 16'd0, 0, 1, 1, 0, 0);
    idle(0, 16'd0, 0, 0, 1, 0, 0);
    idle(1, 16'd0, 0, 0, 0, 0, 0);
    // period 10: stop at 5 holds count; stop+start stays idle
    add(1, 1, 0, 1, 16'd10, 8'd0, 0, 16'd0, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) idle(0, 16'(k), 1, 0, 0, 0, 0);
    add(1, 0, 1, 0, 16'd0, 8'd0, 0, 16'd5, 0, 0, 0, 0, 0);
    idle(0, 16'd5, 0, 0, 0, 0, 0);
    add(1, 1, 1, 1, 16'd10, 8'd0, 0, 16'd5, 0, 0, 0, 0, 0);
    idle(0, 16'd5, 0, 0, 0, 0, 0);
    // period 0 rejected
    add(1, 1, 0, 1, 16'd0, 8'd0, 0, 16'd5, 0, 0, 0, 0, 1);
    idle(0, 16'd5, 0, 0, 0, 0, 0);
    // restart on the would-be expiry edge: no tick, count back to 0
    add(1, 1, 0, 0, 16'd4, 8'd0, 0, 16'd0, 1, 0, 0, 0, 0);
    idle(0, 16'd1, 1, 0, 0, 0, 0);
    idle(0, 16'd2, 1, 0, 0, 0, 0);
    idle(0, 16'd3, 1, 0, 0, 0, 0);
    add(1, 1, 0, 0, 16'd4, 8'd0, 0, 16'd0, 1, 0, 0, 0, 0);
    idle(0, 16'd1, 1, 0, 0, 0, 0);
    idle(0, 16'd2, 1, 0, 0, 0, 0);
    idle(0, 16'd3, 1, 0, 0, 0, 0);
    idle(0, 16'd0, 0, 1, 1, 0, 0);
    idle(1, 16'd0, 0, 0, 0, 0, 0);
    // period 1, prescale 1: expiry on every step (every 2 clocks)
    add(1, 1, 0, 1, 16'd1, 8'd1, 0, 16'd0, 1, 0, 0, 0, 0);
    idle(0, 16'd0, 1, 0, 0, 0, 0);
    idle(0, 16'd0, 1, 1, 1, 0, 0);
    idle(0, 16'd0, 1, 0, 1, 0, 0);
    idle(0, 16'd0, 1, 1, 1, 1, 0);
    // reset mid-RUN with flags set, and reset overriding start
    add(0, 0, 0, 0, 16'd0, 8'd0, 0, 16'd0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 16'd3, 8'd0, 0, 16'd0, 0, 0, 0, 0, 0);
    idle(0, 16'd0, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);
    drive_idle();

    // long prescale: period 2, prescale 255, one-shot -> tick 512 clocks after start
    pulse_start(1'b0, 16'd2, 8'd255);
    n = 0;
    while (n < 1000) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 256) check("pre255_mid_count", int'(count), 1);
      if (tick) break;
    end
    check("pre255_tick_edge", n, 512);
    check("pre255_busy_after", int'(busy), 0);
    irq_ack = 1'b1;
    @(posedge clk);
    #1;
    irq_ack = 1'b0;
    check("pre255_ack_irq", int'(irq), 0);

    // periodic spacing: period 5, prescale 2 -> 15 clocks between ticks
    pulse_start(1'b1, 16'd5, 8'd2);
    n = 0;
    last = 0;
    ticks = 0;
    while (n < 200 && ticks < 3) begin
      @(posedge clk);
      #1;
      n++;
      if (tick) begin
        gap = n - last;
        last = n;
        ticks++;
        check($sformatf("spacing_tick%0d", ticks), gap, 15);
      end
    end
    check("spacing_tick_total", ticks, 3);
    check("spacing_overrun", int'(overrun), 1);
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    check("spacing_stop_busy", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
